// File: rtl/uim_cfg_loader.sv
// uim_cfg_loader: configuration loader for a bank of UIM switches.
// Holds NUM_SW 5-bit active-low select codes, accepts commands over a
// valid/ready port, drives the concatenated uim_mux bus and returns one
// response beat per command (READ carries a priority-decoded source index).
// Optional feature: define UIM_CFG_LOCK_EN to enable the sticky LOCK command.
module uim_cfg_loader #(
  parameter int NUM_SW = 8,
  parameter int AW     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [4:0]            cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4:0]            rsp_code,
  output logic [2:0]            rsp_src,
  output logic                  rsp_multi,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [NUM_SW*5-1:0]   uim_mux_bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ERASE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [2:0] OP_ERASE_ALL = 3'b000;
  localparam logic [2:0] OP_WRITE_SEL = 3'b001;
  localparam logic [2:0] OP_WRITE_RAW = 3'b010;
  localparam logic [2:0] OP_READ      = 3'b011;
  localparam logic [2:0] OP_LOCK      = 3'b100;

  localparam logic [AW:0]   NUM_SW_W = (AW+1)'(NUM_SW);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SW - 1);

  // Source index -> active-low one-cold select code (5 maps to all ones).
  function automatic logic [4:0] sel_to_code(input logic [2:0] idx);
    logic [4:0] code;
    case (idx)
      3'd0:    code = 5'b01111;
      3'd1:    code = 5'b10111;
      3'd2:    code = 5'b11011;
      3'd3:    code = 5'b11101;
      3'd4:    code = 5'b11110;
      default: code = 5'b11111;
    endcase
    return code;
  endfunction

  // First zero scanning from bit4 down to bit0 wins; no zero reports 5.
  function automatic logic [2:0] prio_src(input logic [4:0] code);
    logic [2:0] src;
    casez (code)
      5'b0????: src = 3'd0;
      5'b10???: src = 3'd1;
      5'b110??: src = 3'd2;
      5'b1110?: src = 3'd3;
      5'b11110: src = 3'd4;
      default:  src = 3'd5;
    endcase
    return src;
  endfunction

  // Number of zero (selected) bits in a code.
  function automatic logic [2:0] zero_count(input logic [4:0] code);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, ~code[i]};
    end
    return n;
  endfunction

  logic [1:0]              r_state;
  logic [AW-1:0]           r_idx;
  logic [NUM_SW-1:0][4:0]  r_code;
  logic                    r_rsp_valid;
  logic [4:0]              r_rsp_code;
  logic [2:0]              r_rsp_src;
  logic                    r_rsp_multi;
  logic                    r_rsp_err;
  logic                    r_busy;

  logic                    w_addr_ok;
  logic                    w_locked;
  logic                    w_err;
  logic                    w_wr_en;
  logic [4:0]              w_wr_code;
  logic                    w_erase;
  logic [4:0]              w_rd_code;
  logic [2:0]              w_rd_src;
  logic                    w_rd_multi;

`ifdef UIM_CFG_LOCK_EN
  logic                    r_lock;
  logic                    w_lock_set;
  assign w_locked = r_lock;
`else
  assign w_locked = 1'b0;
`endif

  assign w_addr_ok   = ({1'b0, cmd_addr} < NUM_SW_W);
  assign cmd_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_code    = r_rsp_code;
  assign rsp_src     = r_rsp_src;
  assign rsp_multi   = r_rsp_multi;
  assign rsp_err     = r_rsp_err;
  assign busy        = r_busy;
  assign uim_mux_bus = r_code;

  // Decode the presented command: legality, write target and readback data.
  always_comb begin
    w_err      = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_code  = 5'b11111;
    w_erase    = 1'b0;
    w_rd_code  = 5'b00000;
    w_rd_src   = 3'd0;
    w_rd_multi = 1'b0;
`ifdef UIM_CFG_LOCK_EN
    w_lock_set = 1'b0;
`endif
    case (cmd_op)
      OP_ERASE_ALL: begin
        if (w_locked) begin
          w_err = 1'b1;
        end else begin
          w_erase = 1'b1;
        end
      end
      OP_WRITE_SEL: begin
        // cmd_data[4:3] carries no meaning for a source-index write.
        if (!w_addr_ok || (cmd_data[2:0] > 3'd5) || w_locked) begin
          w_err = 1'b1;
        end else begin
          w_wr_en   = 1'b1;
          w_wr_code = sel_to_code(cmd_data[2:0]);
        end
      end
      OP_WRITE_RAW: begin
        if (!w_addr_ok || w_locked) begin
          w_err = 1'b1;
        end else begin
          w_wr_en   = 1'b1;
          w_wr_code = cmd_data;
        end
      end
      OP_READ: begin
        if (!w_addr_ok) begin
          w_err = 1'b1;
        end else begin
          w_rd_code  = r_code[cmd_addr];
          w_rd_src   = prio_src(r_code[cmd_addr]);
          w_rd_multi = (zero_count(r_code[cmd_addr]) > 3'd1);
        end
      end
      OP_LOCK: begin
`ifdef UIM_CFG_LOCK_EN
        w_lock_set = 1'b1;
`else
        w_err = 1'b1;
`endif
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  // Command FSM: accept, erase sweep, response hold until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= {AW{1'b0}};
      r_code      <= {NUM_SW{5'b11111}};
      r_rsp_valid <= 1'b0;
      r_rsp_code  <= 5'd0;
      r_rsp_src   <= 3'd0;
      r_rsp_multi <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (w_erase) begin
              r_state <= ST_ERASE;
              r_idx   <= {AW{1'b0}};
              r_busy  <= 1'b1;
            end else begin
              if (w_wr_en) begin
                r_code[cmd_addr] <= w_wr_code;
              end
              r_rsp_valid <= 1'b1;
              r_rsp_code  <= w_rd_code;
              r_rsp_src   <= w_rd_src;
              r_rsp_multi <= w_rd_multi;
              r_rsp_err   <= w_err;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_ERASE: begin
          // One slice per cycle; the response fields are already zero.
          r_code[r_idx] <= 5'b11111;
          if (r_idx == LAST_IDX) begin
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_idx <= r_idx + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        ST_RESP: begin
          // Clearing the fields on handshake keeps the next ERASE response at zero.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= 5'd0;
            r_rsp_src   <= 3'd0;
            r_rsp_multi <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef UIM_CFG_LOCK_EN
  // Sticky lock bit, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if ((r_state == ST_IDLE) && cmd_valid && w_lock_set) begin
      r_lock <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uim_cfg_loader.sv
// Testbench for uim_cfg_loader: table-driven command vectors with a response
// scoreboard, plus hand sequences for backpressure, erase sweep, reset
// mid-sweep, out-of-range addressing (NUM_SW=6 instance) and LOCK.
module tb_uim_cfg_loader;

  localparam int NSW = 8;
  localparam int AW  = 3;

  typedef struct packed {
    logic [4:0] code;
    logic [2:0] src;
    logic       multi;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [2:0] op;
    logic [2:0] addr;
    logic [4:0] data;
    logic       wr;
    logic [4:0] slice;
    rsp_t       rsp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [2:0]        cmd_op;
  logic [AW-1:0]     cmd_addr;
  logic [4:0]        cmd_data;
  logic              rsp_valid, rsp_ready;
  logic [4:0]        rsp_code;
  logic [2:0]        rsp_src;
  logic              rsp_multi, rsp_err, busy;
  logic [NSW*5-1:0]  uim_mux_bus;

  logic              c6_valid, c6_ready;
  logic [2:0]        c6_op;
  logic [2:0]        c6_addr;
  logic [4:0]        c6_data;
  logic              r6_valid, r6_ready;
  logic [4:0]        r6_code;
  logic [2:0]        r6_src;
  logic              r6_multi, r6_err, busy6;
  logic [29:0]       bus6;

  int n_cmp  = 0;
  int n_fail = 0;

  rsp_t             exp_q[$];
  logic [NSW*5-1:0] m_bus;
  logic [NSW*5-1:0] e_bus;
  vec_t             tbl[23];
  logic             seen;

  uim_cfg_loader #(.NUM_SW(NSW), .AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
    .rsp_src(rsp_src), .rsp_multi(rsp_multi), .rsp_err(rsp_err),
    .busy(busy), .uim_mux_bus(uim_mux_bus)
  );

  uim_cfg_loader #(.NUM_SW(6), .AW(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c6_valid), .cmd_ready(c6_ready), .cmd_op(c6_op),
    .cmd_addr(c6_addr), .cmd_data(c6_data),
    .rsp_valid(r6_valid), .rsp_ready(r6_ready), .rsp_code(r6_code),
    .rsp_src(r6_src), .rsp_multi(r6_multi), .rsp_err(r6_err),
    .busy(busy6), .uim_mux_bus(bus6)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] addr, input logic [4:0] data,
                              input logic wr, input logic [4:0] slice, input rsp_t rsp);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.wr = wr; v.slice = slice; v.rsp = rsp;
    return v;
  endfunction

  // Scoreboard: every completed response handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got code %0h err %0b, expected no response", rsp_code, rsp_err);
      end else begin
        check("rsp", {rsp_code, rsp_src, rsp_multi, rsp_err}, exp_q.pop_front());
      end
    end
  end

  // Drive one command, check the bus after acceptance, wait for its response.
  task automatic send(input logic [2:0] op, input logic [2:0] addr, input logic [4:0] data,
                      input logic wr, input logic [4:0] slice, input rsp_t rsp, input string name);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("%s_ready", name), cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    exp_q.push_back(rsp);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (wr) m_bus[int'(addr)*5 +: 5] = slice;
    check($sformatf("%s_bus", name), uim_mux_bus, m_bus);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no response, expected one within 50 cycles", name);
      exp_q.delete();
    end
  endtask

  // Command to the NUM_SW=6 instance, checked directly (response is 1 cycle later).
  task automatic send6(input logic [2:0] op, input logic [2:0] addr, input logic [4:0] data,
                       input rsp_t rsp, input logic [29:0] exp_bus, input string name);
    c6_valid = 1'b1; c6_op = op; c6_addr = addr; c6_data = data;
    @(posedge clk); #1;
    c6_valid = 1'b0;
    check($sformatf("%s_valid", name), r6_valid, 1'b1);
    check($sformatf("%s_rsp", name), {r6_code, r6_src, r6_multi, r6_err}, rsp);
    check($sformatf("%s_bus", name), bus6, exp_bus);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(3'b001, 3'd3, 5'd2,     1'b1, 5'b11011, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    tbl[1]  = mk(3'b011, 3'd3, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b11011, 3'd2, 1'b0, 1'b0});
    tbl[2]  = mk(3'b010, 3'd0, 5'b10011, 1'b1, 5'b10011, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    tbl[3]  = mk(3'b011, 3'd0, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b10011, 3'd1, 1'b1, 1'b0});
    tbl[4]  = mk(3'b001, 3'd1, 5'd6,     1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1});
    tbl[5]  = mk(3'b001, 3'd1, 5'd7,     1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1});
    tbl[6]  = mk(3'b001, 3'd2, 5'b11100, 1'b1, 5'b11110, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    tbl[7]  = mk(3'b011, 3'd2, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b11110, 3'd4, 1'b0, 1'b0});
    tbl[8]  = mk(3'b011, 3'd5, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b11111, 3'd5, 1'b0, 1'b0});
    tbl[9]  = mk(3'b101, 3'd0, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1});
    tbl[10] = mk(3'b111, 3'd0, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1});
    tbl[11] = mk(3'b010, 3'd7, 5'b00000, 1'b1, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    tbl[12] = mk(3'b011, 3'd7, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b1, 1'b0});
    tbl[13] = mk(3'b001, 3'd4, 5'd0,     1'b1, 5'b01111, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    tbl[14] = mk(3'b011, 3'd4, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b01111, 3'd0, 1'b0, 1'b0});
    tbl[15] = mk(3'b001, 3'd5, 5'd3,     1'b1, 5'b11101, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    tbl[16] = mk(3'b001, 3'd6, 5'd1,     1'b1, 5'b10111, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    tbl[17] = mk(3'b011, 3'd6, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b10111, 3'd1, 1'b0, 1'b0});
    tbl[18] = mk(3'b001, 3'd1, 5'd5,     1'b1, 5'b11111, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    tbl[19] = mk(3'b011, 3'd5, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b11101, 3'd3, 1'b0, 1'b0});
    tbl[20] = mk(3'b011, 3'd1, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b11111, 3'd5, 1'b0, 1'b0});
    tbl[21] = mk(3'b010, 3'd1, 5'b01010, 1'b1, 5'b01010, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    tbl[22] = mk(3'b011, 3'd1, 5'd0,     1'b0, 5'b00000, rsp_t'{5'b01010, 3'd0, 1'b1, 1'b0});

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 3'd0; cmd_data = 5'd0; rsp_ready = 1'b1;
    c6_valid = 1'b0; c6_op = 3'd0; c6_addr = 3'd0; c6_data = 5'd0; r6_ready = 1'b1;
    m_bus = {NSW{5'b11111}};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("reset_bus", uim_mux_bus, 40'hFF_FFFF_FFFF);
    check("reset_ready", cmd_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_busy", busy, 1'b0);

    // Table-driven vectors
    for (int i = 0; i < 23; i++) begin
      send(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].wr, tbl[i].slice, tbl[i].rsp,
           $sformatf("vec%0d", i));
    end

    // Out-of-range addressing on the NUM_SW=6 instance
    send6(3'b011, 3'd6, 5'd0,     rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1}, 30'h3FFF_FFFF, "oor_read6");
    send6(3'b010, 3'd7, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1}, 30'h3FFF_FFFF, "oor_wraw7");
    send6(3'b001, 3'd5, 5'd1,     rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0}, {5'b10111, 25'h1FF_FFFF}, "ok_wsel5");
    send6(3'b011, 3'd5, 5'd0,     rsp_t'{5'b10111, 3'd1, 1'b0, 1'b0}, {5'b10111, 25'h1FF_FFFF}, "ok_read5");

    // Full ERASE_ALL sweep over mixed contents
    check("erase_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_addr = 3'd0; cmd_data = 5'd0;
    exp_q.push_back(rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < NSW; k++) begin
      e_bus = m_bus;
      for (int j = 0; j < k; j++) e_bus[j*5 +: 5] = 5'b11111;
      check($sformatf("erase_busy%0d", k), busy, 1'b1);
      check($sformatf("erase_bus%0d", k), uim_mux_bus, e_bus);
      check($sformatf("erase_norsp%0d", k), rsp_valid, 1'b0);
      @(posedge clk); #1;
    end
    m_bus = {NSW{5'b11111}};
    check("erase_done_busy", busy, 1'b0);
    check("erase_done_rsp", rsp_valid, 1'b1);
    check("erase_done_bus", uim_mux_bus, m_bus);
    @(posedge clk); #1;
    check("erase_rsp_popped", exp_q.size(), 0);

    // Reset asserted mid-sweep
    send(3'b001, 3'd2, 5'd0,     1'b1, 5'b01111, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0}, "pre_rst_a");
    send(3'b010, 3'd6, 5'b10101, 1'b1, 5'b10101, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0}, "pre_rst_b");
    cmd_valid = 1'b1; cmd_op = 3'b000;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_busy_before", busy, 1'b1);
    check("midrst_slice6_before", uim_mux_bus[34:30], 5'b10101);
    rst_n = 1'b0;
    #1;
    check("midrst_bus", uim_mux_bus, 40'hFF_FFFF_FFFF);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    #5 rst_n = 1'b1;
    m_bus = {NSW{5'b11111}};
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("midrst_no_rsp", seen, 1'b0);
    @(posedge clk); #1;
    check("midrst_ready", cmd_ready, 1'b1);
    check("midrst_bus_after", uim_mux_bus, m_bus);

    // Backpressure on a READ response
    send(3'b001, 3'd3, 5'd2, 1'b1, 5'b11011, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0}, "bp_wsel");
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_addr = 3'd3; cmd_data = 5'd0;
    exp_q.push_back(rsp_t'{5'b11011, 3'd2, 1'b0, 1'b0});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), rsp_valid, 1'b1);
      check($sformatf("bp_ready%0d", k), cmd_ready, 1'b0);
      check($sformatf("bp_hold%0d", k), {rsp_code, rsp_src, rsp_multi, rsp_err},
            rsp_t'{5'b11011, 3'd2, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", rsp_valid, 1'b0);
    check("bp_release_ready", cmd_ready, 1'b1);
    check("bp_release_popped", exp_q.size(), 0);

    // LOCK behaviour
    send(3'b001, 3'd1, 5'd4, 1'b1, 5'b11110, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0}, "prelock_wsel");
`ifdef UIM_CFG_LOCK_EN
    send(3'b100, 3'd0, 5'd0, 1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0}, "lock");
    send(3'b001, 3'd1, 5'd2, 1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1}, "locked_wsel");
    send(3'b010, 3'd1, 5'd0, 1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1}, "locked_wraw");
    send(3'b000, 3'd0, 5'd0, 1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1}, "locked_erase");
    send(3'b011, 3'd1, 5'd0, 1'b0, 5'b00000, rsp_t'{5'b11110, 3'd4, 1'b0, 1'b0}, "locked_read");
    send(3'b100, 3'd0, 5'd0, 1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0}, "relock");
`else
    send(3'b100, 3'd0, 5'd0, 1'b0, 5'b00000, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b1}, "lock_illegal");
    send(3'b001, 3'd1, 5'd2, 1'b1, 5'b11011, rsp_t'{5'b00000, 3'd0, 1'b0, 1'b0}, "nolock_wsel");
    send(3'b011, 3'd1, 5'd0, 1'b0, 5'b00000, rsp_t'{5'b11011, 3'd2, 1'b0, 1'b0}, "nolock_read");
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
